// File: rtl/text_console_pkg.sv
// Shared definitions for the text console controller.
// Contents: default screen geometry, controller state encoding,
// ASCII control codes and the printable range, and cell_addr(), which
// packs (row, col) into the 11-bit text buffer address.
package text_console_pkg;

  localparam int COLS_DEF = 64;
  localparam int ROWS_DEF = 30;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_CLR_ALL  = 2'd2
  } state_e;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // Text buffer address is {row[4:0], col[5:0]}.
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_console_ctrl.sv
// Character-stream controller for the VGA text buffer.
// It takes bytes over a valid/ready handshake, tracks the cursor and
// turns every byte into at most one buffer write. It also runs the
// blocking clears: one row when the screen wraps, and the whole screen
// on reset, on form feed or on cmd_clear.
// Ports:
//   clock, reset        system clock, async active-low reset
//   char_valid/ready    byte handshake (char_ready is combinational)
//   char_data           ASCII byte
//   cmd_clear           level clear-screen request, same as 0x0C
//   wenable/waddr/wdata text buffer write port ({row,col}, {8'h00,ascii})
//   cursor_col/row      current cursor position
//   busy                a clear is in progress
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        cmd_clear,
  output logic        wenable,
  output logic [10:0] waddr,
  output logic [15:0] wdata,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  state_e      state;
  // One counter serves both clears: [5:0] is the column, [10:6] the row.
  logic [10:0] clr_ctr;
  wire  [5:0]  clr_col = clr_ctr[5:0];
  wire  [4:0]  clr_row = clr_ctr[10:6];

  logic        is_print, is_ff, row_adv, wrap, do_wr;
  logic [5:0]  nxt_col;
  logic [4:0]  nxt_row;
  logic [10:0] wr_addr;
  logic [7:0]  wr_ch;

  assign char_ready = (state == ST_IDLE) && !cmd_clear;
  assign busy       = (state != ST_IDLE);

  // Decode of the offered byte against the current cursor.
  always_comb begin
    is_print = (char_data >= PRINT_LO) && (char_data <= PRINT_HI);
    is_ff    = (char_data == CH_FF);
    nxt_col  = cursor_col;
    nxt_row  = cursor_row;
    row_adv  = 1'b0;
    do_wr    = 1'b0;
    wr_addr  = cell_addr(cursor_row, cursor_col);
    wr_ch    = char_data;
    if (is_print) begin
      do_wr = 1'b1;
      if (cursor_col == COL_LAST) begin
        nxt_col = '0;
        row_adv = 1'b1;
      end else begin
        nxt_col = cursor_col + 6'd1;
      end
    end else begin
      case (char_data)
        CH_LF: begin
          nxt_col = '0;
          row_adv = 1'b1;
        end
        CH_CR: nxt_col = '0;
        CH_BS: if (cursor_col != '0) begin
          nxt_col = cursor_col - 6'd1;
          do_wr   = 1'b1;
          wr_addr = cell_addr(cursor_row, cursor_col - 6'd1);
          wr_ch   = 8'h00;
        end
        default: ;
      endcase
    end
    wrap = row_adv && (cursor_row == ROW_LAST);
    if (row_adv) nxt_row = wrap ? 5'd0 : cursor_row + 5'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLR_ALL;
      clr_ctr    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      wenable    <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
    end else begin
      wenable <= 1'b0;
      case (state)
        ST_IDLE: begin
          // cmd_clear wins over a byte offered in the same cycle.
          if (cmd_clear || (char_valid && is_ff)) begin
            state      <= ST_CLR_ALL;
            clr_ctr    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else if (char_valid) begin
            cursor_col <= nxt_col;
            cursor_row <= nxt_row;
            if (do_wr) begin
              wenable <= 1'b1;
              waddr   <= wr_addr;
              wdata   <= {8'h00, wr_ch};
            end
            // Screen wrapped: blank the row the cursor just landed on.
            if (wrap) begin
              state   <= ST_CLR_LINE;
              clr_ctr <= cell_addr(nxt_row, 6'd0);
            end
          end
        end
        ST_CLR_LINE, ST_CLR_ALL: begin
          wenable <= 1'b1;
          waddr   <= clr_ctr;
          wdata   <= '0;
          // Step field-wise so rows past ROW_LAST are never addressed.
          if (clr_col == COL_LAST) begin
            if (state == ST_CLR_LINE || clr_row == ROW_LAST) state <= ST_IDLE;
            else clr_ctr <= cell_addr(clr_row + 5'd1, 6'd0);
          end else begin
            clr_ctr <= cell_addr(clr_row, clr_col + 6'd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl. Expected buffer writes,
// each stamped with the cycle it must appear in, are queued when the
// stimulus goes in; a monitor pops and compares every observed write.
module tb_text_console_ctrl;

  localparam int COLS  = 64;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clock = 1'b0, reset = 1'b0;
  logic        char_valid = 1'b0, cmd_clear = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready, wenable, busy;
  logic [10:0] waddr;
  logic [15:0] wdata;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clock(clock), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .cmd_clear(cmd_clear), .wenable(wenable),
    .waddr(waddr), .wdata(wdata), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [10:0] addr; logic [15:0] data; int cyc; } wr_t;
  wr_t sb[$];

  int tests = 0, fails = 0, nwr = 0;
  int mcol = 0, mrow = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int row, input int col, input logic [15:0] d, input int stamp);
    wr_t e;
    e.addr = 11'(row * COLS + col);
    e.data = d;
    e.cyc  = stamp;
    sb.push_back(e);
  endtask

  task automatic push_clear_all(input int first);
    for (int i = 0; i < CELLS; i++) push(i / COLS, i % COLS, 16'h0000, first + i);
  endtask

  task automatic push_clear_row(input int row, input int first);
    for (int c = 0; c < COLS; c++) push(row, c, 16'h0000, first + c);
  endtask

  // Reference behaviour: base is the cycle count just before the accept edge.
  task automatic adv_row(input int base);
    if (mrow == ROWS - 1) begin
      mrow = 0;
      push_clear_row(0, base + 2);
    end else mrow++;
  endtask

  task automatic model(input logic [7:0] b, input int base);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(mrow, mcol, {8'h00, b}, base + 1);
      if (mcol == COLS - 1) begin mcol = 0; adv_row(base); end
      else mcol++;
    end else if (b == 8'h0A) begin
      mcol = 0; adv_row(base);
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin mcol--; push(mrow, mcol, 16'h0000, base + 1); end
    end else if (b == 8'h0C) begin
      mcol = 0; mrow = 0; push_clear_all(base + 2);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [7:0] b, input bit use_model, output int waited);
    int t = 0;
    char_valid = 1'b1;
    char_data  = b;
    #1;
    while (!char_ready && t < 5000) begin @(negedge clock); #1; t++; end
    waited = t;
    if (!char_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles", b, t);
    end else if (use_model) model(b, cyc);
    @(negedge clock);
    if (use_model) begin
      chk("cursor_col", cursor_col, mcol);
      chk("cursor_row", cursor_row, mrow);
    end
  endtask

  // Called at the falling edge where the clear started counting; expects busy to fall after 1920 edges.
  task automatic wait_clear(input string name);
    int n = 0;
    while (n < 3000) begin
      @(negedge clock); n++;
      if (!busy) break;
    end
    chk(name, n, CELLS);
    chk("clear_cursor", {cursor_row, cursor_col}, 0);
  endtask

  always @(negedge clock) begin
    if (wenable) begin
      wr_t e;
      nwr++;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: addr %0h data %0h cycle %0d, none expected", waddr, wdata, cyc);
      end else begin
        e = sb.pop_front();
        chk("write{addr,data,cycle}", {waddr, wdata, cyc}, {e.addr, e.data, e.cyc});
      end
    end
  end

  typedef struct {
    logic [7:0]  ch;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [5:0]  col;
    logic [4:0]  row;
  } vec_t;
  vec_t vt[12];

  initial begin
    int w, n, nwr0;
    // Streamed back to back from cursor (0,0).
    vt[0]  = '{8'h41, 1'b1, 11'h000, 8'h41, 6'd1, 5'd0};  // 'A'
    vt[1]  = '{8'h42, 1'b1, 11'h001, 8'h42, 6'd2, 5'd0};  // 'B'
    vt[2]  = '{8'h01, 1'b0, 11'h000, 8'h00, 6'd2, 5'd0};  // discarded control
    vt[3]  = '{8'h08, 1'b1, 11'h001, 8'h00, 6'd1, 5'd0};  // backspace
    vt[4]  = '{8'h0D, 1'b0, 11'h000, 8'h00, 6'd0, 5'd0};  // CR
    vt[5]  = '{8'h08, 1'b0, 11'h000, 8'h00, 6'd0, 5'd0};  // backspace at col 0
    vt[6]  = '{8'h0A, 1'b0, 11'h000, 8'h00, 6'd0, 5'd1};  // LF
    vt[7]  = '{8'h78, 1'b1, 11'h040, 8'h78, 6'd1, 5'd1};  // 'x'
    vt[8]  = '{8'h7F, 1'b0, 11'h000, 8'h00, 6'd1, 5'd1};  // DEL, not printable
    vt[9]  = '{8'h7E, 1'b1, 11'h041, 8'h7E, 6'd2, 5'd1};  // '~' upper bound
    vt[10] = '{8'h20, 1'b1, 11'h042, 8'h20, 6'd3, 5'd1};  // space lower bound
    vt[11] = '{8'h1F, 1'b0, 11'h000, 8'h00, 6'd3, 5'd1};  // just below printable

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_wenable", wenable, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_char_ready", char_ready, 0);

    // Power-on clear
    push_clear_all(cyc + 1);
    reset = 1'b1;
    wait_clear("poweron_clear_len");

    // Table vectors, one byte per cycle
    for (int i = 0; i < 12; i++) begin
      if (vt[i].we) begin
        wr_t e;
        e.addr = vt[i].addr; e.data = {8'h00, vt[i].data}; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      send(vt[i].ch, 1'b0, w);
      chk("vec_no_stall", w, 0);
      chk("vec_cursor", {cursor_row, cursor_col}, {vt[i].row, vt[i].col});
    end
    char_valid = 1'b0;
    mcol = 3; mrow = 1;

    // Walk to (29,63), then wrap
    @(negedge clock);
    send(8'h0D, 1'b1, w);
    for (int i = 0; i < 28; i++) send(8'h0A, 1'b1, w);
    for (int i = 0; i < 63; i++) send(8'h2E, 1'b1, w);
    chk("pre_wrap_cursor", {cursor_row, cursor_col}, {5'd29, 6'd63});
    send(8'h5A, 1'b1, w);
    char_valid = 1'b0;
    n = 0;
    #1;
    while (!char_ready && n < 200) begin @(negedge clock); #1; n++; end
    chk("wrap_ready_low_cycles", n, COLS);

    // cmd_clear beats a same-cycle byte
    @(negedge clock);
    cmd_clear = 1'b1; char_valid = 1'b1; char_data = 8'h51;
    #1;
    chk("clear_blocks_ready", char_ready, 0);
    push_clear_all(cyc + 2);
    mcol = 0; mrow = 0;
    @(negedge clock);
    cmd_clear = 1'b0;
    send(8'h51, 1'b1, w);
    chk("clear_accept_wait", w, CELLS);
    char_valid = 1'b0;

    // Reset in the middle of a clear
    @(negedge clock);
    cmd_clear = 1'b1;
    push_clear_all(cyc + 2);
    nwr0 = nwr;
    @(negedge clock);
    cmd_clear = 1'b0;
    repeat (700) @(negedge clock);
    #2;
    chk("midclear_writes", nwr - nwr0, 700);
    reset = 1'b0;
    #1;
    chk("abort_wenable", wenable, 0);
    chk("abort_waddr", waddr, 0);
    chk("abort_wdata", wdata, 0);
    chk("abort_busy", busy, 1);
    chk("abort_char_ready", char_ready, 0);
    sb.delete();
    mcol = 0; mrow = 0;
    repeat (2) @(negedge clock);
    push_clear_all(cyc + 1);
    reset = 1'b1;
    wait_clear("restart_clear_len");

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Character-stream controller that sequences all writes into the VGA text buffer (64 col × 30 row, 8-bit ASCII cells). Accepts bytes from the CPU I/O path through a valid/ready handshake and tracks a hardware cursor. Handles line wrap, newline, carriage return, backspace and form feed. Runs a blocking row clear on screen wrap and a full-screen clear on reset or request. Its write port is bound at top level onto io_interface's wenable/waddr/wdata, which feeds vga_driver.

## Interface
Parameters:
- COLS, 64, text columns; address field waddr[5:0]
- ROWS, 30, text rows; address field waddr[10:6]

Ports:
- clock  in  1  system clock; the same clock as io.clock
- reset  in  1  asynchronous, active-low reset
- char_valid  in  1  char_data is offered
- char_data  in  8  ASCII byte
- char_ready  out  1  byte is accepted on a rising edge when char_valid && char_ready
- cmd_clear  in  1  level-sampled clear-screen request; treated identically to 0x0C
- wenable  out  1  text buffer write strobe
- waddr  out  11  {row[4:0], col[5:0]}
- wdata  out  16  {8'h00, ascii}
- cursor_col  out  6  current cursor column
- cursor_row  out  5  current cursor row
- busy  out  1  high when the state is not IDLE

## Operation
- States: IDLE, CLR_LINE, CLR_ALL. Reset enters CLR_ALL with the clear counter at 0.
- char_ready = (state == IDLE) && !cmd_clear. Combinational. cmd_clear has priority over char_valid in the same cycle.
- Accepted byte handling in IDLE:
  - Printable (0x20–0x7E): write at the cursor, then advance. At col COLS-1 the cursor goes to col 0 of the next row.
  - 0x0A (newline): col to 0, advance row.
  - 0x0D (carriage return): col to 0, no write.
  - 0x08 (backspace): if col > 0, decrement col and write 0x00 at the new position. If col = 0, no-op.
  - 0x0C (form feed): enter CLR_ALL and set the cursor to (0,0).
  - Any other byte: accepted and discarded. No write, cursor unchanged.
- Row advance:
  - From row < ROWS-1, the row increments and the state stays IDLE.
  - From row ROWS-1, the row wraps to 0 and the state enters CLR_LINE targeting row 0.
  - In general, CLR_LINE always targets the new cursor row.
- CLR_LINE: writes 0x00 to {row, 0}..{row, COLS-1}, one per cycle, then returns to IDLE.
- CLR_ALL: writes 0x00 to addresses in row-major order, rows 0..ROWS-1 and cols 0..COLS-1, one per cycle, then returns to IDLE.
- Unused address space is never written: rows 30/31 and waddr values above 1919.
- cmd_clear while busy is ignored. It is re-sampled once the state is back in IDLE.
- Reset mid-operation aborts any clear, zeroes the cursor, and restarts CLR_ALL from address 0.

## Timing
- All outputs except char_ready are registered.
- Reset values: wenable 0, waddr 0, wdata 0, cursor_col 0, cursor_row 0, busy 1. char_ready is 0 during reset.
- Accept at edge N:
  - The resulting write is visible in the cycle after edge N (1-cycle latency).
  - The cursor update is visible after edge N.
  - Printable bytes sustain one byte per cycle.
- Wrap at edge N:
  - Any character write appears after edge N.
  - Clear writes appear after edges N+1..N+COLS.
  - char_ready is low after edge N and high after edge N+COLS.
- Clear (0x0C or cmd_clear sampled at edge N):
  - Writes appear after edges N+1..N+ROWS·COLS (1920).
  - char_ready is high after edge N+1920.
- After reset release: clear writes appear after edges 1..1920, and busy falls after edge 1920.
- wenable is 0 in every cycle that has no scheduled write.

## Structure
- Package text_console_pkg holds:
  - COLS/ROWS defaults
  - the state enum
  - ASCII constants: CH_BS=0x08, CH_LF=0x0A, CH_FF=0x0C, CH_CR=0x0D, PRINT_LO=0x20, PRINT_HI=0x7E
  - the helper function cell_addr(row, col) returning 11 bits
- One flat module. The clear sequencer is an 11-bit counter split into col/row fields, shared by CLR_LINE and CLR_ALL. No sub-module is needed.

## Test plan
- Reset release, no input -> 1920 consecutive writes of wdata 0x0000, addresses 0x000..0x77F excluding 0x780+. busy falls after edge 1920 and the cursor is (0,0).
- Send "AB", char_valid held for 2 cycles -> writes {0,0}=0x41 then {0,1}=0x42 on consecutive cycles. Cursor ends at (0,2).
- At cursor (0,5), send 0x08 then 0x0D -> one write {0,4}=0x00, then the cursor goes to (0,0) with no write.
- At cursor (29,63), send 'Z' -> write waddr {29,63}=0x5A, then 64 writes clearing row 0. char_ready is low for 64 cycles and the cursor is (0,0).
- Assert cmd_clear and char_valid ('Q') in the same IDLE cycle -> 'Q' is not accepted and a full clear runs. 'Q' is accepted 1920 cycles later and written at {0,0}.
- Pulse reset low during a clear at counter 700 -> outputs return to reset values immediately. The clear restarts at address 0 and completes 1920 writes.
